// File: rtl/solver_vector_bank_if.sv
// Bus bundle for solver_vector_bank: load/ALU write ports, dual-bank read port,
// swap handshake and status. Master drives requests, slave is the bank.
interface solver_vector_bank_if #(
    parameter int ELEMENT_WIDTH = 64,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDR_WIDTH    = 8
) ();
    localparam int DW = ELEMENT_WIDTH * NO_OF_UNITS;

    logic [ADDR_WIDTH:0]   total_rows;
    logic                  load_we;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DW-1:0]         load_data;
    logic                  wr_we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DW-1:0]         wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DW-1:0]         rd_cur;
    logic [DW-1:0]         rd_next;
    logic                  rd_valid;
    logic                  swap_req;
    logic                  swap_ack;
    logic                  next_complete;
    logic                  swap_err;
    logic                  bank_sel;

    modport master (
        output total_rows, load_we, load_addr, load_data,
        output wr_we, wr_addr, wr_data, rd_en, rd_addr, swap_req,
        input  rd_cur, rd_next, rd_valid, swap_ack, next_complete, swap_err, bank_sel
    );

    modport slave (
        input  total_rows, load_we, load_addr, load_data,
        input  wr_we, wr_addr, wr_data, rd_en, rd_addr, swap_req,
        output rd_cur, rd_next, rd_valid, swap_ack, next_complete, swap_err, bank_sel
    );
endinterface

// File: rtl/solver_vector_bank.sv
// Double-buffered solver vector store: current bank is read/loaded, next bank fills
// from the ALU and is swapped in once complete. Define SOLVER_VBANK_FWD_EN for write-to-read forwarding.
module solver_vector_bank #(
    parameter int ELEMENT_WIDTH = 64,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDR_WIDTH    = 8
) (
    input logic               clk,
    input logic               reset,
    solver_vector_bank_if.slave bus
);
    localparam int DW    = ELEMENT_WIDTH * NO_OF_UNITS;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    logic [DW-1:0]         bank0_r [DEPTH];
    logic [DW-1:0]         bank1_r [DEPTH];
    state_t                state_r, state_next_s;
    logic                  bank_sel_r;
    logic [ADDR_WIDTH:0]   total_rows_r;
    logic [ADDR_WIDTH:0]   cnt_r;
    logic [DEPTH-1:0]      written_r;
    logic                  next_complete_r;
    logic                  swap_ack_r;
    logic                  swap_err_r;
    logic                  rd_valid_r;
    logic [DW-1:0]         rd_cur_r;
    logic [DW-1:0]         rd_next_r;

    logic                  wr_ok_s;
    logic                  first_s;
    logic [ADDR_WIDTH:0]   cnt_after_s;
    logic                  complete_now_s;
    logic                  accept_s;
    logic                  bank0_we_s, bank1_we_s;
    logic [ADDR_WIDTH-1:0] bank0_addr_s, bank1_addr_s;
    logic [DW-1:0]         bank0_data_s, bank1_data_s;
    logic [DW-1:0]         cur_rd_s, next_rd_s;

    // Count this cycle's write before judging the swap, so a completing write can ride along with swap_req.
    assign wr_ok_s        = bus.wr_we && ({1'b0, bus.wr_addr} < total_rows_r);
    assign first_s        = wr_ok_s && !written_r[bus.wr_addr];
    assign cnt_after_s    = cnt_r + {{ADDR_WIDTH{1'b0}}, first_s};
    assign complete_now_s = (cnt_after_s == total_rows_r);
    assign accept_s       = bus.swap_req && ((state_r == READY) || complete_now_s);

    // Steer load (current bank) and ALU write (next bank) onto the two physical banks.
    always_comb begin
        bank0_we_s   = 1'b0;
        bank1_we_s   = 1'b0;
        bank0_addr_s = bus.wr_addr;
        bank1_addr_s = bus.wr_addr;
        bank0_data_s = bus.wr_data;
        bank1_data_s = bus.wr_data;
        if (reset) begin
            bank0_we_s = 1'b0;
            bank1_we_s = 1'b0;
        end else if (bank_sel_r == 1'b0) begin
            bank0_we_s   = bus.load_we;
            bank0_addr_s = bus.load_addr;
            bank0_data_s = bus.load_data;
            bank1_we_s   = wr_ok_s;
        end else begin
            bank1_we_s   = bus.load_we;
            bank1_addr_s = bus.load_addr;
            bank1_data_s = bus.load_data;
            bank0_we_s   = wr_ok_s;
        end
    end

    // Bank storage; contents deliberately survive reset and swap.
    always_ff @(posedge clk) begin
        if (bank0_we_s) begin
            bank0_r[bank0_addr_s] <= bank0_data_s;
        end
        if (bank1_we_s) begin
            bank1_r[bank1_addr_s] <= bank1_data_s;
        end
    end

    // Read-side selection with optional same-row write forwarding.
    always_comb begin
        cur_rd_s  = bank0_r[bus.rd_addr];
        next_rd_s = bank1_r[bus.rd_addr];
        if (bank_sel_r == 1'b1) begin
            cur_rd_s  = bank1_r[bus.rd_addr];
            next_rd_s = bank0_r[bus.rd_addr];
        end else begin
            cur_rd_s  = bank0_r[bus.rd_addr];
            next_rd_s = bank1_r[bus.rd_addr];
        end
`ifdef SOLVER_VBANK_FWD_EN
        if (bus.load_we && (bus.load_addr == bus.rd_addr)) begin
            cur_rd_s = bus.load_data;
        end else begin
            cur_rd_s = cur_rd_s;
        end
        if (wr_ok_s && (bus.wr_addr == bus.rd_addr)) begin
            next_rd_s = bus.wr_data;
        end else begin
            next_rd_s = next_rd_s;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = IDLE;
                end else if (wr_ok_s) begin
                    state_next_s = complete_now_s ? READY : FILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                if (accept_s) begin
                    state_next_s = IDLE;
                end else if (complete_now_s) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = FILL;
                end
            end
            READY: begin
                if (accept_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = READY;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Fill tracking, swap handshake and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_sel_r      <= 1'b0;
            cnt_r           <= {(ADDR_WIDTH+1){1'b0}};
            written_r       <= {DEPTH{1'b0}};
            next_complete_r <= 1'b0;
            swap_ack_r      <= 1'b0;
            swap_err_r      <= 1'b0;
            total_rows_r    <= bus.total_rows;
        end else begin
            swap_ack_r <= accept_s;
            if (accept_s) begin
                bank_sel_r      <= ~bank_sel_r;
                cnt_r           <= {(ADDR_WIDTH+1){1'b0}};
                written_r       <= {DEPTH{1'b0}};
                next_complete_r <= 1'b0;
                total_rows_r    <= bus.total_rows;
            end else begin
                cnt_r           <= cnt_after_s;
                next_complete_r <= complete_now_s;
                if (wr_ok_s) begin
                    written_r[bus.wr_addr] <= 1'b1;
                end
            end
            if (bus.swap_req && !accept_s) begin
                swap_err_r <= 1'b1;
            end
        end
    end

    // Registered read port; data holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_cur_r   <= {DW{1'b0}};
            rd_next_r  <= {DW{1'b0}};
        end else begin
            rd_valid_r <= bus.rd_en;
            if (bus.rd_en) begin
                rd_cur_r  <= cur_rd_s;
                rd_next_r <= next_rd_s;
            end
        end
    end

    assign bus.rd_cur        = rd_cur_r;
    assign bus.rd_next       = rd_next_r;
    assign bus.rd_valid      = rd_valid_r;
    assign bus.swap_ack      = swap_ack_r;
    assign bus.next_complete = next_complete_r;
    assign bus.swap_err      = swap_err_r;
    assign bus.bank_sel      = bank_sel_r;
endmodule

// File: tb/tb_solver_vector_bank.sv
// Directed scoreboard bench for solver_vector_bank: reads push expectations, a negedge
// monitor pops them on rd_valid; status flags are checked inline.
module tb_solver_vector_bank;
    localparam int EW = 64;
    localparam int N  = 8;
    localparam int A  = 8;
    localparam int DW = EW * N;
`ifdef SOLVER_VBANK_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] cur;
        logic [DW-1:0] nxt;
        bit            cc;
        bit            cn;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    solver_vector_bank_if #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(N), .ADDR_WIDTH(A)) bus ();

    solver_vector_bank #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(N), .ADDR_WIDTH(A)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [DW-1:0] mk(input int tag, input int row);
        logic [DW-1:0] v;
        v = {DW{1'b0}};
        for (int u = 0; u < N; u++) begin
            v[u*EW +: EW] = {tag[7:0], row[7:0], u[7:0], 8'h5A, tag[15:0], row[15:0]};
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.load_we  = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.wr_we    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.swap_req = 1'b0;
    endtask

    task automatic do_load(input int row, input int tag);
        bus.load_we = 1'b1; bus.load_addr = row[A-1:0]; bus.load_data = mk(tag, row);
        tick();
        bus.load_we = 1'b0;
    endtask

    task automatic do_wr(input int row, input int tag);
        bus.wr_we = 1'b1; bus.wr_addr = row[A-1:0]; bus.wr_data = mk(tag, row);
        tick();
        bus.wr_we = 1'b0;
    endtask

    task automatic do_rd(input int row, input logic [DW-1:0] ec, input logic [DW-1:0] en,
                         input bit cc, input bit cn);
        q.push_back('{cur: ec, nxt: en, cc: cc, cn: cn});
        bus.rd_en = 1'b1; bus.rd_addr = row[A-1:0];
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_swap();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            if (q.size() == 0) begin
                chk("rd_valid_unexpected", {{(DW-1){1'b0}}, bus.rd_valid}, {DW{1'b0}});
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cc) chk("rd_cur", bus.rd_cur, e.cur);
                if (e.cn) chk("rd_next", bus.rd_next, e.nxt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        bus.total_rows = 9'd4;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_bank_sel", bus.bank_sel, 0);
        chk("rst_swap_ack", bus.swap_ack, 0);
        chk("rst_swap_err", bus.swap_err, 0);
        chk("rst_next_complete", bus.next_complete, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_cur", bus.rd_cur, 0);
        chk("rst_rd_next", bus.rd_next, 0);

        // Load current bank, read row 2 back one cycle later.
        for (int r = 0; r < 5; r++) do_load(r, 1);
        do_rd(2, mk(1, 2), '0, 1'b1, 1'b0);
        chk("rd_valid_high", bus.rd_valid, 1);
        tick();
        chk("rd_valid_pulse_end", bus.rd_valid, 0);
        chk("rd_cur_hold", bus.rd_cur, mk(1, 2));

        // Swap rejected while only 2 of 4 rows filled.
        do_wr(0, 2);
        chk("nc_after_1", bus.next_complete, 0);
        do_wr(1, 2);
        do_swap();
        chk("fill_swap_err", bus.swap_err, 1);
        chk("fill_bank_sel", bus.bank_sel, 0);
        chk("fill_swap_ack", bus.swap_ack, 0);

        // Completing write, swap and read all in one cycle.
        do_wr(2, 2);
        chk("nc_after_3", bus.next_complete, 0);
        q.push_back('{cur: mk(1, 3), nxt: mk(2, 3), cc: 1'b1, cn: FWD});
        bus.wr_we = 1'b1; bus.wr_addr = 8'd3; bus.wr_data = mk(2, 3);
        bus.swap_req = 1'b1; bus.rd_en = 1'b1; bus.rd_addr = 8'd3;
        tick();
        clear_inputs();
        chk("combo_swap_ack", bus.swap_ack, 1);
        chk("combo_bank_sel", bus.bank_sel, 1);
        chk("combo_nc_cleared", bus.next_complete, 0);
        tick();
        chk("swap_ack_pulse_end", bus.swap_ack, 0);
        do_rd(3, mk(2, 3), mk(1, 3), 1'b1, 1'b1);

        // Fill bank0 with a rewrite and an out-of-range write.
        do_wr(0, 3); chk("e_nc_0", bus.next_complete, 0);
        do_wr(1, 3); chk("e_nc_1", bus.next_complete, 0);
        do_wr(1, 4); chk("e_nc_rewrite", bus.next_complete, 0);
        do_wr(2, 3); chk("e_nc_2", bus.next_complete, 0);
        do_wr(4, 3); chk("e_nc_oor", bus.next_complete, 0);
        do_wr(3, 3); chk("e_nc_done", bus.next_complete, 1);
        do_wr(3, 5); chk("e_nc_ready_rewrite", bus.next_complete, 1);
        chk("swap_err_sticky", bus.swap_err, 1);
        do_rd(1, mk(2, 1), mk(4, 1), 1'b1, 1'b1);
        do_rd(3, mk(2, 3), mk(5, 3), 1'b1, 1'b1);
        do_rd(4, '0, mk(1, 4), 1'b0, 1'b1);

        // Swap in READY with total_rows re-sampled to 8, then row-5 collision.
        bus.total_rows = 9'd8;
        do_swap();
        chk("ready_swap_ack", bus.swap_ack, 1);
        chk("ready_bank_sel", bus.bank_sel, 0);
        do_load(5, 8);
        do_wr(5, 5);
        q.push_back('{cur: FWD ? mk(7, 5) : mk(8, 5), nxt: FWD ? mk(6, 5) : mk(5, 5), cc: 1'b1, cn: 1'b1});
        bus.load_we = 1'b1; bus.load_addr = 8'd5; bus.load_data = mk(7, 5);
        bus.wr_we = 1'b1; bus.wr_addr = 8'd5; bus.wr_data = mk(6, 5);
        bus.rd_en = 1'b1; bus.rd_addr = 8'd5;
        tick();
        clear_inputs();
        do_rd(5, mk(7, 5), mk(6, 5), 1'b1, 1'b1);
        chk("f_nc_partial", bus.next_complete, 0);

        // Reset mid-fill with concurrent requests; reset must win.
        do_wr(0, 9);
        bus.total_rows = 9'd4;
        reset = 1'b1;
        bus.wr_we = 1'b1; bus.wr_addr = 8'd1; bus.wr_data = mk(9, 1);
        bus.swap_req = 1'b1; bus.rd_en = 1'b1; bus.rd_addr = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        clear_inputs();
        chk("r2_nc", bus.next_complete, 0);
        chk("r2_bank_sel", bus.bank_sel, 0);
        chk("r2_swap_ack", bus.swap_ack, 0);
        chk("r2_swap_err", bus.swap_err, 0);
        chk("r2_rd_valid", bus.rd_valid, 0);
        do_wr(0, 10); do_wr(1, 10); do_wr(2, 10);
        chk("r2_nc_3of4", bus.next_complete, 0);
        do_swap();
        chk("r2_fill_swap_err", bus.swap_err, 1);
        chk("r2_fill_swap_ack", bus.swap_ack, 0);
        do_wr(3, 10);
        chk("r2_nc_done", bus.next_complete, 1);
        do_swap();
        chk("r2_swap_ack", bus.swap_ack, 1);
        chk("r2_bank_sel_1", bus.bank_sel, 1);
        do_rd(5, mk(6, 5), mk(7, 5), 1'b1, 1'b1);
        do_rd(0, mk(10, 0), mk(3, 0), 1'b1, 1'b1);

        tick();
        tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/solver_vector_bank.md
SOLVER_VECTOR_BANK -- requirements
Module: solver_vector_bank

Interface
REQ-001 Parameter ELEMENT_WIDTH, 64, width of one complex element (real [63:32], imag [31:0]).
REQ-002 Parameter NO_OF_UNITS, 8, elements per row.
REQ-003 Parameter ADDR_WIDTH, 8, row address width; each bank holds 2**ADDR_WIDTH rows.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 total_rows  in  ADDR_WIDTH+1  number of valid rows per vector (1..2**ADDR_WIDTH), sampled at each swap and at reset release.
REQ-007 load_we / load_addr / load_data  in  1 / ADDR_WIDTH / ELEMENT_WIDTH*NO_OF_UNITS  initial-vector write into the current bank.
REQ-008 wr_we / wr_addr / wr_data  in  1 / ADDR_WIDTH / ELEMENT_WIDTH*NO_OF_UNITS  ALU result write into the next bank.
REQ-009 rd_en / rd_addr  in  1 / ADDR_WIDTH  read request, both banks, same row.
REQ-010 rd_cur / rd_next  out  ELEMENT_WIDTH*NO_OF_UNITS  registered read data from current and next bank.
REQ-011 rd_valid  out  1  read data valid.
REQ-012 swap_req  in  1  single-cycle request to exchange banks.
REQ-013 swap_ack  out  1  one-cycle pulse, swap accepted.
REQ-014 next_complete  out  1  next bank holds total_rows distinct written rows.
REQ-015 swap_err  out  1  sticky, swap requested while next_complete low.
REQ-016 bank_sel  out  1  index of the current bank.

Function
REQ-017 Two banks, bank[bank_sel] is current, bank[~bank_sel] is next.
REQ-018 Read latency 1 cycle: rd_en at cycle N -> rd_cur, rd_next, rd_valid=1 at N+1; rd_valid=0 otherwise; rd_cur/rd_next hold last value when rd_en low.
REQ-019 load_we writes current bank; wr_we writes next bank; both may occur in the same cycle.
REQ-020 Per-row written bitmap for next bank; write counter increments only on the first write to a row; rewrite of a row updates data, not the counter.
REQ-021 wr_addr >= total_rows: write ignored, counter unchanged.
REQ-022 next_complete = (counter == total_rows), registered, asserted the cycle after the completing write.
REQ-023 States IDLE, FILL, READY: IDLE -> FILL on first wr_we; FILL -> READY when next_complete; READY -> IDLE on accepted swap.
REQ-024 swap_req in READY: bank_sel toggles, bitmap and counter clear, swap_ack=1 next cycle, total_rows re-sampled.
REQ-025 swap_req in IDLE or FILL: rejected, no toggle, swap_err set, swap_ack stays 0.
REQ-026 wr_we and swap_req in same cycle: write lands in the pre-swap next bank and counts before swap evaluation; swap accepted if that write completes the vector.
REQ-027 rd_en and accepted swap in same cycle: read uses pre-swap bank_sel.
REQ-028 Bank contents not cleared by swap or reset.

Reset
REQ-029 reset: bank_sel=0, state IDLE, counter and bitmap cleared, rd_valid=0, swap_ack=0, swap_err=0, next_complete=0, rd_cur=rd_next=0.
REQ-030 reset mid-FILL aborts fill; partial next-bank data ignored by counting.
REQ-031 reset dominates all concurrent requests in the same cycle.

Configuration
REQ-032 Macro SOLVER_VBANK_FWD_EN defined: rd_en and wr_we/load_we to the same row in the same cycle return the new write data on rd_next/rd_cur.
REQ-033 Macro undefined: same-cycle collision returns old stored data.

Verification
REQ-034 Load rows 0..3 via load_we, total_rows=4, read row 2 -> rd_cur equals loaded row 2 one cycle later, rd_valid=1 for one cycle.
REQ-035 Write rows 0,1,1,2,3 with total_rows=4 -> next_complete rises after row 3 write, not before; counter never exceeds 4.
REQ-036 swap_req in FILL (2 of 4 rows) -> swap_err=1, bank_sel unchanged, swap_ack=0.
REQ-037 Write row 3 completing and swap_req same cycle -> swap_ack=1 next cycle, bank_sel=1, rd_cur of row 3 returns written data.
REQ-038 Same-cycle wr_we and rd_en on row 5 -> rd_next = new data with SOLVER_VBANK_FWD_EN, old data without.
REQ-039 reset during FILL after 2 writes -> next_complete=0, state IDLE, 4 fresh writes needed to reach READY.
